// File: rtl/counter_pkg.sv
// Shared definitions for the up/down counter: direction encodings, default
// parameter values, the per-edge action type and the prescale phase width helper.
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int DEF_WIDTH    = 8;
  localparam int DEF_PRESCALE = 1;

  typedef enum logic [1:0] {
    STEP_HOLD = 2'd0,
    STEP_LOAD = 2'd1,
    STEP_UP   = 2'd2,
    STEP_DOWN = 2'd3
  } step_t;

  // Phase register width for a divide-by-p prescaler (at least one bit).
  function automatic int phase_width(input int p);
    if (p <= 2) begin
      return 1;
    end
    return $clog2(p);
  endfunction

endpackage

// File: rtl/counter_prescale.sv
// Step-tick generator: tick is high on the enabled cycle that completes each
// PRESCALE-cycle interval; the phase is held while en=0 and zeroed by clr.
module counter_prescale
  import counter_pkg::*;
#(
  parameter int PRESCALE = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic en,
  input  logic clr,
  output logic tick
);

  localparam int PW = phase_width(PRESCALE);
  localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

  logic [PW-1:0] phase_reg;
  logic [PW-1:0] phase_next;

  assign tick = en && (phase_reg == LAST);

  always_comb begin
    phase_next = phase_reg;
    if (clr) begin
      phase_next = '0;
    end else if (en) begin
      phase_next = (phase_reg == LAST) ? '0 : phase_reg + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_reg <= '0;
    end else begin
      phase_reg <= phase_next;
    end
  end

endmodule

// File: rtl/updown_counter.sv
// Prescaled up/down counter with clamped load and a one-cycle terminal-count pulse.
// Define UPDOWN_COUNTER_SAT_EN to add the sat input (saturate at the bounds instead of wrapping).
module updown_counter
  import counter_pkg::*;
#(
  parameter int               WIDTH    = DEF_WIDTH,
  parameter int               PRESCALE = DEF_PRESCALE,
  parameter logic [WIDTH-1:0] MAX_VAL  = {WIDTH{1'b1}}
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef UPDOWN_COUNTER_SAT_EN
  input  logic             sat,
`endif
  output logic [WIDTH-1:0] value,
  output logic             tc
);

  logic             tick;
  logic             sat_mode;
  step_t            act;
  logic [WIDTH-1:0] value_reg;
  logic [WIDTH-1:0] value_next;
  logic             tc_reg;
  logic             tc_next;
  logic             at_max;
  logic             below_max;
  logic             at_zero;
  logic             above_zero;

  generate
    if (PRESCALE == 1) begin : g_bypass
      assign tick = en;
    end else begin : g_prescale
      counter_prescale #(
        .PRESCALE(PRESCALE)
      ) u_prescale (
        .clk  (clk),
        .reset(reset),
        .en   (en),
        .clr  (load),
        .tick (tick)
      );
    end
  endgenerate

`ifdef UPDOWN_COUNTER_SAT_EN
  assign sat_mode = sat;
`else
  assign sat_mode = 1'b0;
`endif

  always_comb begin
    if (load) begin
      act = STEP_LOAD;
    end else if (!tick) begin
      act = STEP_HOLD;
    end else if (dir == DIR_DOWN) begin
      act = STEP_DOWN;
    end else begin
      act = STEP_UP;
    end
  end

  assign at_max     = (value_reg == MAX_VAL);
  assign below_max  = (value_reg == MAX_VAL - 1'b1);
  assign at_zero    = (value_reg == '0);
  assign above_zero = (value_reg == {{(WIDTH-1){1'b0}}, 1'b1});

  // In saturating mode tc marks arrival at the bound; in wrap mode it marks the wrap.
  always_comb begin
    value_next = value_reg;
    tc_next    = 1'b0;
    case (act)
      STEP_LOAD: begin
        value_next = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      end
      STEP_UP: begin
        if (at_max) begin
          if (!sat_mode) begin
            value_next = '0;
            tc_next    = 1'b1;
          end
        end else begin
          value_next = value_reg + 1'b1;
          tc_next    = sat_mode && below_max;
        end
      end
      STEP_DOWN: begin
        if (at_zero) begin
          if (!sat_mode) begin
            value_next = MAX_VAL;
            tc_next    = 1'b1;
          end
        end else begin
          value_next = value_reg - 1'b1;
          tc_next    = sat_mode && above_zero;
        end
      end
      default: begin
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      value_reg <= '0;
      tc_reg    <= 1'b0;
    end else begin
      value_reg <= value_next;
      tc_reg    <= tc_next;
    end
  end

  assign value = value_reg;
  assign tc    = tc_reg;

endmodule

// File: tb/tb_updown_counter.sv
// Bench for updown_counter: three instances (full-range, MAX_VAL=9, PRESCALE=4/MAX_VAL=100)
// share stimulus and are compared every cycle against an arithmetic reference model.
module tb_updown_counter;

  localparam int N = 3;
  localparam int PRE[N] = '{1, 1, 4};
  localparam int MX[N]  = '{255, 9, 100};

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       en = 1'b0;
  logic       dir = 1'b1;
  logic       load = 1'b0;
  logic [7:0] load_val = 8'd0;
  logic       sat_m;
`ifdef UPDOWN_COUNTER_SAT_EN
  logic       sat = 1'b0;
  assign sat_m = sat;
`else
  assign sat_m = 1'b0;
`endif

  logic [7:0] v0, v1, v2;
  logic       tc0, tc1, tc2;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  updown_counter #(.WIDTH(8), .PRESCALE(1)) d0 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNTER_SAT_EN
    .sat(sat),
`endif
    .value(v0), .tc(tc0)
  );

  updown_counter #(.WIDTH(8), .PRESCALE(1), .MAX_VAL(8'd9)) d1 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNTER_SAT_EN
    .sat(sat),
`endif
    .value(v1), .tc(tc1)
  );

  updown_counter #(.WIDTH(8), .PRESCALE(4), .MAX_VAL(8'd100)) d2 (
    .clk(clk), .reset(reset), .en(en), .dir(dir), .load(load), .load_val(load_val),
`ifdef UPDOWN_COUNTER_SAT_EN
    .sat(sat),
`endif
    .value(v2), .tc(tc2)
  );

  logic [7:0] dv[N];
  logic       dtc[N];
  assign dv[0] = v0;
  assign dv[1] = v1;
  assign dv[2] = v2;
  assign dtc[0] = tc0;
  assign dtc[1] = tc1;
  assign dtc[2] = tc2;

  // Reference model: value in 0..mx, enabled-cycle count within the prescale interval.
  int mv[N]  = '{0, 0, 0};
  int mph[N] = '{0, 0, 0};
  int mtc[N] = '{0, 0, 0};

  function automatic int next_val(input int v, input int mx, input bit up, input bit s);
    if (up) begin
      return s ? ((v + 1 > mx) ? mx : v + 1) : (v + 1) % (mx + 1);
    end
    return s ? ((v == 0) ? 0 : v - 1) : (v + mx) % (mx + 1);
  endfunction

  function automatic int next_tc(input int v, input int mx, input bit up, input bit s);
    int n;
    n = next_val(v, mx, up, s);
    if (s) begin
      return ((n != v) && (n == (up ? mx : 0))) ? 1 : 0;
    end
    return (up ? (n < v) : (n > v)) ? 1 : 0;
  endfunction

  always @(posedge clk or negedge reset) begin
    for (int k = 0; k < N; k++) begin
      if (!reset) begin
        mv[k]  <= 0;
        mph[k] <= 0;
        mtc[k] <= 0;
      end else if (load) begin
        mv[k]  <= (int'(load_val) > MX[k]) ? MX[k] : int'(load_val);
        mph[k] <= 0;
        mtc[k] <= 0;
      end else if (en && (mph[k] == PRE[k] - 1)) begin
        mv[k]  <= next_val(mv[k], MX[k], dir, sat_m);
        mtc[k] <= next_tc(mv[k], MX[k], dir, sat_m);
        mph[k] <= 0;
      end else begin
        if (en) begin
          mph[k] <= mph[k] + 1;
        end
        mtc[k] <= 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp, input bit show);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end else if (show) begin
      $display("chk %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    for (int k = 0; k < N; k++) begin
      chk($sformatf("model_value[%0d]", k), {24'd0, dv[k]}, mv[k], 1'b0);
      chk($sformatf("model_tc[%0d]", k), {31'd0, dtc[k]}, mtc[k], 1'b0);
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    cyc(2);
    chk("reset_value", v0, 0, 1'b1);
    chk("reset_tc", tc0, 0, 1'b1);

    // Full count-up from reset with wrap.
    reset = 1'b1; en = 1'b1; dir = 1'b1;
    cyc(255);
    chk("up_to_ff", v0, 8'hFF, 1'b1);
    chk("up_to_ff_tc", tc0, 0, 1'b1);
    cyc(1);
    chk("wrap_value", v0, 0, 1'b1);
    chk("wrap_tc", tc0, 1, 1'b1);
    cyc(1);
    chk("after_wrap_value", v0, 1, 1'b1);
    chk("after_wrap_tc", tc0, 0, 1'b1);

    // Down-count wrap from zero.
    load = 1'b1; load_val = 8'd0;
    cyc(1);
    load = 1'b0; dir = 1'b0;
    chk("load0_tc", tc0, 0, 1'b1);
    cyc(1);
    chk("down_wrap_ff", v0, 8'hFF, 1'b1);
    chk("down_wrap_ff_tc", tc0, 1, 1'b1);
    chk("down_wrap_9", v1, 9, 1'b1);
    chk("down_wrap_9_tc", tc1, 1, 1'b1);

    // Prescale by 4 with an en=0 gap.
    load = 1'b1; load_val = 8'd0; dir = 1'b1;
    cyc(1);
    load = 1'b0;
    cyc(3);
    chk("pre_before_step", v2, 0, 1'b1);
    cyc(1);
    chk("pre_first_step", v2, 1, 1'b1);
    cyc(1);
    en = 1'b0;
    cyc(2);
    en = 1'b1;
    cyc(2);
    chk("pre_delayed_hold", v2, 1, 1'b1);
    cyc(1);
    chk("pre_delayed_step", v2, 2, 1'b1);

    // Load wins over count; clamp to MAX_VAL.
    load = 1'b1; load_val = 8'h80;
    cyc(1);
    chk("load_80", v0, 8'h80, 1'b1);
    chk("load_80_tc", tc0, 0, 1'b1);
    chk("load_80_clamp100", v2, 100, 1'b1);
    load_val = 8'hF0;
    cyc(1);
    chk("load_f0", v0, 8'hF0, 1'b1);
    chk("load_f0_clamp100", v2, 100, 1'b1);
    chk("load_f0_clamp9", v1, 9, 1'b1);

    // Asynchronous reset between edges.
    load_val = 8'h37; en = 1'b0;
    cyc(1);
    load = 1'b0;
    chk("load_37", v0, 8'h37, 1'b1);
    #2 reset = 1'b0;
    #1;
    chk("async_rst_value", v0, 0, 1'b1);
    chk("async_rst_value_pre", v2, 0, 1'b1);
    @(posedge clk);
    #1;
    reset = 1'b1; en = 1'b1; dir = 1'b1;
    cyc(3);
    chk("rst_release_v0", v0, 3, 1'b1);
    chk("rst_release_no_step", v2, 0, 1'b1);
    cyc(1);
    chk("rst_release_first_step", v2, 1, 1'b1);

`ifdef UPDOWN_COUNTER_SAT_EN
    load = 1'b1; load_val = 8'hFE; en = 1'b0;
    cyc(1);
    load = 1'b0; sat = 1'b1; en = 1'b1; dir = 1'b1;
    cyc(1);
    chk("sat_reach_ff", v0, 8'hFF, 1'b1);
    chk("sat_reach_tc", tc0, 1, 1'b1);
    cyc(1);
    chk("sat_hold_ff", v0, 8'hFF, 1'b1);
    chk("sat_hold_tc", tc0, 0, 1'b1);
    sat = 1'b0;
`endif

    // Randomized traffic, checked every cycle against the model.
    for (int i = 0; i < 3000; i++) begin
      en = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 31) == 0) dir = ~dir;
      load = ($urandom_range(0, 23) == 0);
      load_val = 8'($urandom);
`ifdef UPDOWN_COUNTER_SAT_EN
      if ($urandom_range(0, 63) == 0) sat = ~sat;
`endif
      if ($urandom_range(0, 249) == 0) begin
        #2 reset = 1'b0;
      end
      cyc(1);
      reset = 1'b1;
    end

    @(negedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
